// File: rtl/seg_scan_ctrl_if.sv
// Digit-scan control bundle: scan enable and mask toward the scanner, digit select,
// index and frame pulse back toward the display stage.
interface seg_scan_ctrl_if #(
    parameter int unsigned DIGITS = 8
);
    logic              en;
    logic [DIGITS-1:0] digit_mask;
    logic [DIGITS-1:0] sel;
    logic [2:0]        sel_idx;
    logic              frame_tick;

    modport master (
        output en,
        output digit_mask,
        input  sel,
        input  sel_idx,
        input  frame_tick
    );

    modport slave (
        input  en,
        input  digit_mask,
        output sel,
        output sel_idx,
        output frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 7-segment digit scanner: steps a one-hot select through the enabled digits, holding
// each for DIV cycles, and pulses frame_tick whenever the scan wraps to the first digit.
// Optional feature: define SEG_SCAN_BLANKING_EN to blank sel for the first BLANK_CYC
// cycles of every slot (anti-ghosting).
module seg_scan_ctrl #(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned DIV       = 50000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_ctrl_if.slave   bus
);
    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic              ft_q, ft_d;
    logic [2:0]        lo_idx;
    logic [2:0]        nxt_idx;

    // Lowest set bit of the mask (0 when the mask is empty).
    function automatic logic [2:0] lowest_set(input logic [DIGITS-1:0] mask);
        logic [2:0] r;
        r = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Next set bit strictly above cur, searching cyclically; returns cur itself when it is
    // the only set bit. Descending k so the nearest candidate wins.
    function automatic logic [2:0] next_set(input logic [DIGITS-1:0] mask,
                                            input logic [2:0] cur);
        logic [2:0]  r;
        int unsigned j;
        r = cur;
        for (int unsigned k = DIGITS; k >= 1; k--) begin
            j = (int'(cur) + k) % DIGITS;
            if (mask[j]) r = 3'(j);
        end
        return r;
    endfunction

    assign lo_idx  = lowest_set(bus.digit_mask);
    assign nxt_idx = next_set(bus.digit_mask, idx_q);

    // Next-state, dwell counter and registered-output inputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ft_d    = 1'b0;
        sel_d   = '0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.en && |bus.digit_mask) begin
                    state_d = StScan;
                    idx_d   = lo_idx;
                    ft_d    = 1'b1;
                end
            end
            StScan: begin
                if (!bus.en || ~|bus.digit_mask) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(DIV - 1)) begin
                    cnt_d = '0;
                    idx_d = nxt_idx;
                    // Wrap detected when the search did not move to a higher index.
                    ft_d  = (nxt_idx <= idx_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StScan) begin
            // Masking with the live mask drops sel as soon as the current digit is disabled.
            sel_d = (DIGITS'(1) << idx_d) & bus.digit_mask;
`ifdef SEG_SCAN_BLANKING_EN
            if (32'(cnt_d) < BLANK_CYC) sel_d = '0;
`endif
        end
    end

    // State and output registers; async reset forces outputs low without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            ft_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            ft_q    <= ft_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.sel_idx    = idx_q;
    assign bus.frame_tick = ft_q;
endmodule
